// File: rtl/ccmul_pkg.sv
// Shared widths and the accumulator-width helper for the 8x8 multiply/accumulate path.
package ccmul_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Smallest accumulator that can hold len full-scale products without wrapping.
    function automatic int min_acc_w(input int len);
        return PROD_W + $clog2(len);
    endfunction

endpackage

// File: rtl/CCMul8.sv
// Registered unsigned 8x8 multiplier; the product register is the dot-product stage 2.
module CCMul8
    import ccmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    output logic [PROD_W-1:0] o_p
);

    logic [PROD_W-1:0] r_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= PROD_W'(i_a) * PROD_W'(i_b);
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/dot8_acc.sv
// Streaming unsigned dot-product accumulator: operand register, registered multiply,
// LEN-product accumulator and a valid/ready result register.
module dot8_acc
    import ccmul_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] SUM
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    generate
        if (LEN < 1 || LEN > 256) begin : g_bad_len
            $error("dot8_acc: LEN must be in 1..256");
        end
        if (ACC_W < min_acc_w(LEN)) begin : g_bad_acc_w
            $error("dot8_acc: ACC_W too narrow for LEN");
        end
    endgenerate

    logic              r_v1;
    logic [OP_W-1:0]   r_a1;
    logic [OP_W-1:0]   r_b1;
    logic              r_v2;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_sum;
    logic              r_out_valid;

    logic              w_en;
    logic              w_accept;
    logic              w_last;
    logic              w_done;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_sum_next;

    // Whole pipeline advances together; a pending unconsumed result freezes it.
    assign w_en       = !r_out_valid || out_ready;
    assign in_ready   = w_en && !clr;
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_done     = w_en && r_v2 && w_last && !clr;
    assign w_sum_next = r_acc + ACC_W'(w_prod);

    CCMul8 u_mul (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_en),
        .i_a  (r_a1),
        .i_b  (r_b1),
        .o_p  (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_a1        <= '0;
            r_b1        <= '0;
            r_v2        <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (clr) begin
                r_v1  <= 1'b0;
                r_v2  <= 1'b0;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_en) begin
                r_v1 <= w_accept;
                if (w_accept) begin
                    r_a1 <= A;
                    r_b1 <= B;
                end
                r_v2 <= r_v1;
                if (r_v2) begin
                    if (w_last) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_acc <= w_sum_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // A completing result takes priority over release so nothing is dropped.
            if (w_done) begin
                r_sum       <= w_sum_next;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign SUM       = r_sum;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_dot8_acc.sv
// Self-checking bench for dot8_acc: LEN=4 and LEN=1 instances with result scoreboards.
module tb_dot8_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr;
    logic        in_valid4, in_ready4, ov4, out_ready4;
    logic [7:0]  a4, b4;
    logic [23:0] sum4;
    logic        in_valid1, in_ready1, ov1, out_ready1;
    logic [7:0]  a1, b1;
    logic [15:0] sum1;

    dot8_acc #(.LEN(4), .ACC_W(24)) dut4 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid4), .in_ready(in_ready4), .A(a4), .B(b4),
        .out_valid(ov4), .out_ready(out_ready4), .SUM(sum4)
    );

    dot8_acc #(.LEN(1), .ACC_W(16)) dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid1), .in_ready(in_ready1), .A(a1), .B(b1),
        .out_valid(ov1), .out_ready(out_ready1), .SUM(sum1)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int unsigned exp;
    } vec_t;

    vec_t        tbl[5];
    int          checks = 0;
    int          errors = 0;
    int unsigned q4[$];
    int unsigned q1[$];
    int          oc4[$];
    int          oc1[$];
    int          cyc = 0;
    bit          acc4, acc1;
    int unsigned m_acc;
    int          m_cnt;
    int unsigned cur_exp1;
    int          stall_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One clock: model/scoreboard bookkeeping at the falling edge, return #1 after the rise.
    task automatic cycle();
        @(negedge clk);
        acc4 = 1'b0;
        acc1 = 1'b0;
        if (rst) begin
            m_acc = 0;
            m_cnt = 0;
            q4.delete();
            q1.delete();
        end else begin
            if (ov4 && out_ready4) begin
                oc4.push_back(cyc);
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sum4_unexpected: got %0d, no result expected", sum4);
                end else begin
                    check("sum4", 32'(sum4), q4.pop_front());
                end
            end
            if (ov1 && out_ready1) begin
                oc1.push_back(cyc);
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sum1_unexpected: got %0d, no result expected", sum1);
                end else begin
                    check("sum1", 32'(sum1), q1.pop_front());
                end
            end
            if (clr) begin
                m_acc = 0;
                m_cnt = 0;
            end else if (in_valid4 && in_ready4) begin
                acc4  = 1'b1;
                m_acc = m_acc + a4 * b4;
                m_cnt++;
                if (m_cnt == 4) begin
                    q4.push_back(m_acc);
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
            if (!clr && in_valid1 && in_ready1) begin
                acc1 = 1'b1;
                q1.push_back(cur_exp1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b);
        bit got = 1'b0;
        a4 = a;
        b4 = b;
        in_valid4 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (acc4) begin
                got = 1'b1;
                break;
            end
        end
        in_valid4 = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send4_timeout: beat (%0d,%0d) never accepted", a, b);
        end
    endtask

    task automatic send1(input logic [7:0] a, input logic [7:0] b, input int unsigned exp);
        bit got = 1'b0;
        a1 = a;
        b1 = b;
        cur_exp1 = exp;
        in_valid1 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (acc1) begin
                got = 1'b1;
                break;
            end
        end
        in_valid1 = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send1_timeout: beat (%0d,%0d) never accepted", a, b);
        end
    endtask

    task automatic idle(input int n);
        in_valid4 = 1'b0;
        in_valid1 = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
        m_acc = 0; m_cnt = 0; cur_exp1 = 0;

        tbl[0] = '{8'd200, 8'd100, 20000};
        tbl[1] = '{8'd7,   8'd9,   63};
        tbl[2] = '{8'd255, 8'd255, 65025};
        tbl[3] = '{8'd0,   8'd77,  0};
        tbl[4] = '{8'd1,   8'd1,   1};

        // Reset state
        cycle();
        cycle();
        check("rst_out_valid4", 32'(ov4), 0);
        check("rst_sum4", 32'(sum4), 0);
        check("rst_in_ready4", 32'(in_ready4), 1);
        check("rst_out_valid1", 32'(ov1), 0);
        check("rst_in_ready1", 32'(in_ready1), 1);
        rst = 1'b0;

        // Single vector and its latency
        oc4.delete();
        send4(8'd1, 8'd1);
        send4(8'd2, 8'd3);
        send4(8'd255, 8'd255);
        send4(8'd16, 8'd16);
        check("t1_ov_edge_n", 32'(ov4), 0);
        cycle();
        check("t1_ov_edge_n1", 32'(ov4), 0);
        cycle();
        check("t1_ov_edge_n2", 32'(ov4), 1);
        check("t1_sum_edge_n2", 32'(sum4), 65288);
        idle(3);

        // Back-to-back full-scale vectors
        oc4.delete();
        repeat (8) send4(8'd255, 8'd255);
        idle(4);
        check("t2_results", oc4.size(), 2);
        if (oc4.size() >= 2) check("t2_spacing", 32'(oc4[1] - oc4[0]), 4);

        // Back-pressure while a second vector streams in
        out_ready4 = 1'b0;
        oc4.delete();
        send4(8'd1, 8'd1);
        send4(8'd2, 8'd1);
        send4(8'd3, 8'd1);
        send4(8'd4, 8'd1);
        send4(8'd5, 8'd1);
        send4(8'd6, 8'd1);
        check("t3_pending", 32'(ov4), 1);
        check("t3_in_ready_low", 32'(in_ready4), 0);
        a4 = 8'd7; b4 = 8'd1; in_valid4 = 1'b1;
        stall_acc = 0;
        repeat (5) begin
            cycle();
            if (acc4) stall_acc++;
        end
        check("t3_stall_accepts", stall_acc, 0);
        out_ready4 = 1'b1;
        send4(8'd7, 8'd1);
        send4(8'd8, 8'd1);
        idle(5);
        check("t3_results", oc4.size(), 2);

        // clr discards the partial vector and blocks the beat offered with it
        oc4.delete();
        send4(8'd9, 8'd9);
        send4(8'd9, 8'd9);
        clr = 1'b1;
        a4 = 8'd50; b4 = 8'd50; in_valid4 = 1'b1;
        #1;
        check("t4_in_ready_clr", 32'(in_ready4), 0);
        cycle();
        check("t4_clr_beat_taken", 32'(acc4), 0);
        clr = 1'b0;
        in_valid4 = 1'b0;
        repeat (4) send4(8'd3, 8'd3);
        idle(4);
        check("t4_results", oc4.size(), 1);

        // Reset mid-vector with a result pending
        out_ready4 = 1'b0;
        repeat (4) send4(8'd1, 8'd1);
        send4(8'd2, 8'd2);
        send4(8'd2, 8'd2);
        idle(2);
        check("t5_pending", 32'(ov4), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5_rst_ov", 32'(ov4), 0);
        check("t5_rst_sum", 32'(sum4), 0);
        check("t5_rst_in_ready", 32'(in_ready4), 1);
        out_ready4 = 1'b1;
        oc4.delete();
        repeat (4) send4(8'd2, 8'd2);
        idle(4);
        check("t5_results", oc4.size(), 1);

        // LEN=1: every beat is a result
        oc1.delete();
        for (int i = 0; i < 5; i++) send1(tbl[i].a, tbl[i].b, tbl[i].exp);
        idle(4);
        check("t6_results", oc1.size(), 5);
        if (oc1.size() >= 2) check("t6_spacing", 32'(oc1[1] - oc1[0]), 1);

        check("q4_drained", q4.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
